fetch_redirect_ctrl: RTL and testbench

- Sequences the fetch stage around the NPC mux of the RV32I pipeline.
- Drives npc_sel to the NPC mux and pc_en to the PC register.
- Owns the single-outstanding instruction-memory handshake, with a 1-entry hold buffer.
- Generates IF/ID and ID/EX flush/bubble controls for redirects (br, jalr, jal) and load-use hazards, and kills wrong-path fetches already in flight.

---
 rtl/fetch_ctrl_pkg.sv | 28 ++
 rtl/load_use_detect.sv | 22 ++
 rtl/fetch_redirect_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch redirect controller: NPC mux selects and FSM states.
// Also provides the redirect-priority helper used to drive npc_sel.
package fetch_ctrl_pkg;

    localparam logic [1:0] NPC_SEL_SEQ  = 2'd0;
    localparam logic [1:0] NPC_SEL_JAL  = 2'd1;
    localparam logic [1:0] NPC_SEL_JALR = 2'd2;
    localparam logic [1:0] NPC_SEL_BR   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        KILL  = 2'd2
    } fetch_state_e;

    // EX-stage redirects are older than the ID-stage jal, so they win.
    function automatic logic [1:0] npc_sel_f(input logic br, input logic jalr, input logic jal);
        if (br) begin
            return NPC_SEL_BR;
        end else if (jalr) begin
            return NPC_SEL_JALR;
        end else if (jal) begin
            return NPC_SEL_JAL;
        end
        return NPC_SEL_SEQ;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator between the EX load and the ID sources.
// x0 never creates a hazard since it is never written.
module load_use_detect (
    input  logic       ex_mem2reg,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    output logic       lu
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = id_rs1_used && (ex_rd == id_rs1);
        rs2_hit = id_rs2_used && (ex_rd == id_rs2);
        lu      = ex_mem2reg && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage sequencer: NPC select, PC enable, single-outstanding imem handshake with a
// 1-entry hold buffer, and IF/ID / ID/EX flush/bubble. Optional counters: FETCH_REDIRECT_CNT_EN.
module fetch_redirect_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br,
    input  logic              jalr,
    input  logic              jal,
    input  logic              ex_mem2reg,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [1:0]        npc_sel,
    output logic              pc_en,
    output logic [INST_W-1:0] inst_d,
    output logic              inst_valid_d,
    output logic              bubbleD,
    output logic              flushD,
    output logic              flushE
`ifdef FETCH_REDIRECT_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt_br,
    output logic [CNT_W-1:0]  cnt_jalr,
    output logic [CNT_W-1:0]  cnt_jal,
    output logic [CNT_W-1:0]  cnt_kill
`endif
);

    fetch_state_e      state_q, state_d;
    logic              hold_valid_q, hold_valid_d;
    logic [INST_W-1:0] hold_q, hold_d;
    logic              lu;
    logic              redirect;

    load_use_detect u_lu (
        .ex_mem2reg (ex_mem2reg),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used),
        .lu         (lu)
    );

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        redirect     = br || jalr || jal;
        imem_req     = 1'b0;
        pc_en        = 1'b0;
        npc_sel      = NPC_SEL_SEQ;
        inst_d       = hold_valid_q ? hold_q : imem_rdata;
        inst_valid_d = 1'b0;
        bubbleD      = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;

        if (rst) begin
            flushD       = 1'b1;
            flushE       = 1'b1;
            state_d      = IDLE;
            hold_valid_d = 1'b0;
        end else begin
            npc_sel = npc_sel_f(br, jalr, jal);
            // A redirect makes the stalled ID instruction wrong-path, so it beats the stall.
            if (redirect) begin
                pc_en        = 1'b1;
                flushD       = 1'b1;
                flushE       = br || jalr;
                hold_valid_d = 1'b0;
            end else if (lu) begin
                bubbleD = 1'b1;
                flushE  = 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    imem_req = !hold_valid_q;
                    if (hold_valid_q) begin
                        // No request is in flight while holding, so a redirect stays in FETCH.
                        if (!redirect && !lu) begin
                            inst_valid_d = 1'b1;
                            pc_en        = 1'b1;
                            hold_valid_d = 1'b0;
                        end
                    end else if (imem_ack) begin
                        if (!redirect) begin
                            if (lu) begin
                                hold_d       = imem_rdata;
                                hold_valid_d = 1'b1;
                            end else begin
                                inst_d       = imem_rdata;
                                inst_valid_d = 1'b1;
                                pc_en        = 1'b1;
                            end
                        end
                    end else if (redirect) begin
                        state_d = KILL;
                    end
                end
                KILL: begin
                    imem_req = !hold_valid_q;
                    if (imem_ack) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
        end
        hold_q <= hold_d;
    end

`ifdef FETCH_REDIRECT_CNT_EN
    logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
    logic [CNT_W-1:0] cnt_jalr_q, cnt_jalr_d;
    logic [CNT_W-1:0] cnt_jal_q, cnt_jal_d;
    logic [CNT_W-1:0] cnt_kill_q, cnt_kill_d;
    logic             ack_discard;

    always_comb begin
        cnt_br_d    = cnt_br_q;
        cnt_jalr_d  = cnt_jalr_q;
        cnt_jal_d   = cnt_jal_q;
        cnt_kill_d  = cnt_kill_q;
        ack_discard = imem_ack && ((state_q == KILL) ||
                      ((state_q == FETCH) && !hold_valid_q && redirect));
        if (br) begin
            cnt_br_d = cnt_br_q + CNT_W'(1);
        end else if (jalr) begin
            cnt_jalr_d = cnt_jalr_q + CNT_W'(1);
        end else if (jal) begin
            cnt_jal_d = cnt_jal_q + CNT_W'(1);
        end
        if (ack_discard) begin
            cnt_kill_d = cnt_kill_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_br_q   <= '0;
            cnt_jalr_q <= '0;
            cnt_jal_q  <= '0;
            cnt_kill_q <= '0;
        end else begin
            cnt_br_q   <= cnt_br_d;
            cnt_jalr_q <= cnt_jalr_d;
            cnt_jal_q  <= cnt_jal_d;
            cnt_kill_q <= cnt_kill_d;
        end
    end

    assign cnt_br   = cnt_br_q;
    assign cnt_jalr = cnt_jalr_q;
    assign cnt_jal  = cnt_jal_q;
    assign cnt_kill = cnt_kill_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus random traffic checked against a
// transaction-level model (request in flight, wrong-path flag, held-instruction queue).
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst, br, jalr, jal, ex_mem2reg;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        id_rs1_used, id_rs2_used, imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req, pc_en, inst_valid_d, bubbleD, flushD, flushE;
    logic [1:0]  npc_sel;
    logic [31:0] inst_d;
`ifdef FETCH_REDIRECT_CNT_EN
    logic [31:0] cnt_br, cnt_jalr, cnt_jal, cnt_kill;
`endif

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk(clk), .rst(rst), .br(br), .jalr(jalr), .jal(jal),
        .ex_mem2reg(ex_mem2reg), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .npc_sel(npc_sel), .pc_en(pc_en), .inst_d(inst_d), .inst_valid_d(inst_valid_d),
        .bubbleD(bubbleD), .flushD(flushD), .flushE(flushE)
`ifdef FETCH_REDIRECT_CNT_EN
        , .cnt_br(cnt_br), .cnt_jalr(cnt_jalr), .cnt_jal(cnt_jal), .cnt_kill(cnt_kill)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model state: first cycle after reset, request in flight, in-flight request is wrong-path,
    // instruction parked behind a load-use stall.
    bit          m_idle, m_busy, m_wrong;
    logic [31:0] m_held[$];
    logic [31:0] m_cnt_br, m_cnt_jalr, m_cnt_jal, m_cnt_kill;
    bit          n_idle, n_busy, n_wrong;
    logic [31:0] n_held[$];
    logic [31:0] n_cnt_br, n_cnt_jalr, n_cnt_jal, n_cnt_kill;
    logic [7:0]  exp_o;
    logic [31:0] exp_inst;
    bit          exp_issue;

    function automatic logic [7:0] outs();
        return {imem_req, pc_en, npc_sel, inst_valid_d, bubbleD, flushD, flushE};
    endfunction

    task automatic model_eval();
        bit lu_e, redir, req, ack_eff, discard;
        logic [1:0] sel;
        lu_e  = ex_mem2reg && (ex_rd != 0) &&
                ((id_rs1_used && ex_rd == id_rs1) || (id_rs2_used && ex_rd == id_rs2));
        redir = br || jalr || jal;
        exp_issue = 0;
        exp_inst  = 32'h0;
        n_held    = m_held;
        if (rst) begin
            exp_o = 8'b0000_0011;
            n_idle = 1; n_busy = 0; n_wrong = 0;
            n_held.delete();
            n_cnt_br = 0; n_cnt_jalr = 0; n_cnt_jal = 0; n_cnt_kill = 0;
        end else begin
            req     = !m_idle && (m_held.size() == 0);
            ack_eff = imem_ack && m_busy;
            discard = 0;
            if (m_held.size() != 0) begin
                if (redir) n_held.delete();
                else if (!lu_e) begin
                    exp_issue = 1;
                    exp_inst  = m_held[0];
                    n_held.delete();
                end
            end else if (ack_eff) begin
                if (m_wrong || redir) discard = 1;
                else if (lu_e) n_held.push_back(imem_rdata);
                else begin
                    exp_issue = 1;
                    exp_inst  = imem_rdata;
                end
            end
            sel   = br ? 2'd3 : jalr ? 2'd2 : jal ? 2'd1 : 2'd0;
            exp_o = {req, redir || exp_issue, sel, exp_issue, !redir && lu_e, redir,
                     br || jalr || (!redir && lu_e)};
            n_idle  = 0;
            n_busy  = m_busy ? !imem_ack : req;
            n_wrong = ack_eff ? 1'b0 : (m_wrong || (redir && (m_busy || req)));
            n_cnt_br   = m_cnt_br   + (br ? 1 : 0);
            n_cnt_jalr = m_cnt_jalr + ((!br && jalr) ? 1 : 0);
            n_cnt_jal  = m_cnt_jal  + ((!br && !jalr && jal) ? 1 : 0);
            n_cnt_kill = m_cnt_kill + (discard ? 1 : 0);
        end
    endtask

    task automatic settle();
        model_eval();
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        m_idle = n_idle; m_busy = n_busy; m_wrong = n_wrong; m_held = n_held;
        m_cnt_br = n_cnt_br; m_cnt_jalr = n_cnt_jalr; m_cnt_jal = n_cnt_jal; m_cnt_kill = n_cnt_kill;
        #1;
    endtask

    task automatic quiet();
        rst = 0; br = 0; jalr = 0; jal = 0; ex_mem2reg = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_used = 0; id_rs2_used = 0; imem_ack = 0; imem_rdata = $urandom;
    endtask

    task automatic set_lu(input bit on);
        ex_mem2reg = on; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1; id_rs2 = 5'd7; id_rs2_used = 1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            rst = 1; br = $urandom_range(0, 1); jalr = $urandom_range(0, 1); jal = $urandom_range(0, 1);
            ex_mem2reg = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1;
            imem_ack = $urandom_range(0, 1); imem_rdata = $urandom;
            settle();
            checks++;
            if (outs() !== 8'b0000_0011) begin
                errors++; $display("FAIL reset c%0d outs=%b exp=%b", c, outs(), 8'b0000_0011);
            end
            tick();
        end
    endtask

    task automatic test_seq_fetch();
        for (int k = 0; k <= 8; k++) begin
            quiet();
            imem_ack = (k >= 2) && (k % 2 == 0);
            settle();
            checks++;
            if (outs() !== exp_o) begin
                errors++; $display("FAIL seq_fetch c%0d outs=%b exp=%b", k, outs(), exp_o);
            end
            checks++;
            if (imem_req !== (k >= 1)) begin
                errors++; $display("FAIL seq_req c%0d req=%b exp=%b", k, imem_req, k >= 1);
            end
            if (imem_ack) begin
                checks++;
                if ({inst_valid_d, pc_en, npc_sel} !== 4'b1100 || inst_d !== imem_rdata) begin
                    errors++; $display("FAIL seq_accept c%0d v/pc/sel=%b inst=%h exp=1100 %h",
                                       k, {inst_valid_d, pc_en, npc_sel}, inst_d, imem_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect_priority();
        quiet(); br = 1; jal = 1;
        settle();
        checks++;
        if ({npc_sel, pc_en, flushD, flushE} !== 5'b11111 || outs() !== exp_o) begin
            errors++; $display("FAIL prio sel/pc/fd/fe=%b exp=11111", {npc_sel, pc_en, flushD, flushE});
        end
        tick();
        quiet(); imem_ack = 1; imem_rdata = 32'h0000_0013;
        settle();
        checks++;
        if (inst_valid_d !== 1'b0 || pc_en !== 1'b0 || outs() !== exp_o) begin
            errors++; $display("FAIL kill_discard valid=%b pc_en=%b exp=0 0", inst_valid_d, pc_en);
        end
        tick();
        quiet();
        settle();
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL kill_to_fetch_req req=%b exp=1", imem_req);
        end
        tick();
        quiet(); imem_ack = 1;
        settle();
        checks++;
        if (inst_valid_d !== 1'b1 || inst_d !== imem_rdata) begin
            errors++; $display("FAIL post_kill_accept valid=%b inst=%h exp=1 %h", inst_valid_d, inst_d, imem_rdata);
        end
        tick();
    endtask

    task automatic test_load_use();
        quiet(); settle(); tick();
        quiet(); set_lu(1); imem_ack = 1; imem_rdata = 32'h00A0_0093;
        settle();
        checks++;
        if ({bubbleD, flushE, pc_en, inst_valid_d} !== 4'b1100 || outs() !== exp_o) begin
            errors++; $display("FAIL lu_capture bub/fe/pc/v=%b exp=1100", {bubbleD, flushE, pc_en, inst_valid_d});
        end
        tick();
        quiet(); set_lu(1);
        settle();
        checks++;
        if (imem_req !== 1'b0 || bubbleD !== 1'b1 || outs() !== exp_o) begin
            errors++; $display("FAIL lu_hold req=%b bub=%b exp=0 1", imem_req, bubbleD);
        end
        tick();
        quiet();
        settle();
        checks++;
        if (inst_valid_d !== 1'b1 || pc_en !== 1'b1 || inst_d !== 32'h00A0_0093) begin
            errors++; $display("FAIL lu_drain v=%b pc=%b inst=%h exp=1 1 00a00093", inst_valid_d, pc_en, inst_d);
        end
        tick();
    endtask

    task automatic test_ex_rd_zero();
        for (int c = 0; c < 6; c++) begin
            quiet();
            ex_mem2reg = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0; id_rs2_used = 1;
            imem_ack = m_busy;
            settle();
            checks++;
            if (bubbleD !== 1'b0 || flushE !== 1'b0 || outs() !== exp_o) begin
                errors++; $display("FAIL rd_zero c%0d bub=%b fe=%b outs=%b exp=%b", c, bubbleD, flushE, outs(), exp_o);
            end
            tick();
        end
    endtask

    task automatic test_hold_redirect();
        for (int c = 0; c < 4 && !m_busy; c++) begin
            quiet(); settle(); tick();
        end
        quiet(); set_lu(1); imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
        settle(); tick();
        quiet(); set_lu(1); jalr = 1;
        settle();
        checks++;
        if (npc_sel !== 2'd2 || pc_en !== 1'b1 || inst_valid_d !== 1'b0 || outs() !== exp_o) begin
            errors++; $display("FAIL hold_jalr sel=%0d pc=%b v=%b exp=2 1 0", npc_sel, pc_en, inst_valid_d);
        end
        tick();
        quiet();
        settle();
        checks++;
        if (inst_valid_d !== 1'b0 || imem_req !== 1'b1 || outs() !== exp_o) begin
            errors++; $display("FAIL hold_dropped v=%b req=%b exp=0 1", inst_valid_d, imem_req);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            quiet(); imem_ack = m_busy;
            settle();
            checks++;
            if (outs() !== exp_o || (inst_valid_d === 1'b1 && inst_d === 32'hCAFE_F00D)) begin
                errors++; $display("FAIL hold_never_issued c%0d outs=%b exp=%b inst=%h", c, outs(), exp_o, inst_d);
            end
            tick();
        end
    endtask

    task automatic test_kill_redirects();
        quiet(); rst = 1; settle(); tick();
        quiet(); settle(); tick();
        quiet(); settle(); tick();
        quiet(); br = 1; settle(); tick();
        for (int c = 0; c < 2; c++) begin
            quiet();
            if (c == 0) jalr = 1; else jal = 1;
            settle();
            checks++;
            if (pc_en !== 1'b1 || npc_sel !== ((c == 0) ? 2'd2 : 2'd1) || outs() !== exp_o) begin
                errors++; $display("FAIL kill_redirect c%0d pc=%b sel=%0d outs=%b exp=%b", c, pc_en, npc_sel, outs(), exp_o);
            end
            tick();
        end
        quiet(); imem_ack = 1;
        settle();
        checks++;
        if (inst_valid_d !== 1'b0 || pc_en !== 1'b0) begin
            errors++; $display("FAIL kill_ack v=%b pc=%b exp=0 0", inst_valid_d, pc_en);
        end
        tick();
`ifdef FETCH_REDIRECT_CNT_EN
        checks++;
        if ({cnt_br, cnt_jalr, cnt_jal, cnt_kill} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            errors++; $display("FAIL kill_counters br=%0d jalr=%0d jal=%0d kill=%0d exp=1 1 1 1",
                               cnt_br, cnt_jalr, cnt_jal, cnt_kill);
        end
`endif
    endtask

    task automatic test_reset_in_kill();
        quiet(); settle(); tick();
        quiet(); br = 1; settle(); tick();
        quiet(); rst = 1; imem_ack = 1;
        settle();
        checks++;
        if (outs() !== 8'b0000_0011) begin
            errors++; $display("FAIL rst_in_kill outs=%b exp=00000011", outs());
        end
        tick();
        quiet();
        settle();
        checks++;
        if (imem_req !== 1'b0 || outs() !== exp_o) begin
            errors++; $display("FAIL rst_idle req=%b outs=%b exp=%b", imem_req, outs(), exp_o);
        end
        tick();
        quiet();
        settle();
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL rst_refetch req=%b exp=1", imem_req);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            br          = ($urandom_range(0, 9) == 0);
            jalr        = ($urandom_range(0, 11) == 0);
            jal         = ($urandom_range(0, 9) == 0);
            ex_mem2reg  = ($urandom_range(0, 2) == 0);
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            imem_ack    = (m_busy || m_idle) ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata  = $urandom;
            settle();
            checks++;
            if (outs() !== exp_o) begin
                errors++; $display("FAIL random c%0d outs=%b exp=%b", c, outs(), exp_o);
            end
            if (exp_issue) begin
                checks++;
                if (inst_d !== exp_inst) begin
                    errors++; $display("FAIL random_inst c%0d inst=%h exp=%h", c, inst_d, exp_inst);
                end
            end
            tick();
        end
`ifdef FETCH_REDIRECT_CNT_EN
        checks++;
        if ({cnt_br, cnt_jalr, cnt_jal, cnt_kill} !== {m_cnt_br, m_cnt_jalr, m_cnt_jal, m_cnt_kill}) begin
            errors++; $display("FAIL random_counters %0d %0d %0d %0d exp=%0d %0d %0d %0d",
                               cnt_br, cnt_jalr, cnt_jal, cnt_kill, m_cnt_br, m_cnt_jalr, m_cnt_jal, m_cnt_kill);
        end
`endif
    endtask

    initial begin
        m_idle = 1; m_busy = 0; m_wrong = 0;
        m_cnt_br = 0; m_cnt_jalr = 0; m_cnt_jal = 0; m_cnt_kill = 0;
        quiet(); rst = 1;
        @(posedge clk); #1;
        test_reset();
        test_seq_fetch();
        test_redirect_priority();
        test_load_use();
        test_ex_rd_zero();
        test_hold_redirect();
        test_kill_redirects();
        test_reset_in_kill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
